// File: rtl/deskew_interp.sv
// deskew_interp: fetches the source pixel(s) addressed by a Q10.14 x-prime coordinate and blends them.
// Define INTERP_BILINEAR_EN for a two-tap linear blend; otherwise nearest neighbour is built.
module deskew_interp #(
    parameter int               PIX_W  = 8,
    parameter int               FRAC_W = 8,
    parameter logic [PIX_W-1:0] FILL   = 8'h00
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclr,
    input  logic [8:0]       img_dim,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [23:0]      xp_in,
    input  logic [8:0]       x_in,
    input  logic [8:0]       y_in,
    output logic             mem_rd,
    output logic [17:0]      mem_addr,
    input  logic [PIX_W-1:0] mem_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] pix_out,
    output logic [8:0]       out_x,
    output logic [8:0]       out_y,
    output logic             out_oob
);
    typedef enum logic [2:0] {S_IDLE, S_RD0, S_RD1, S_MUL, S_OUT} state_t;

    state_t            r_state, w_next;
    logic [8:0]        w_xi;
    logic [FRAC_W-1:0] w_w;
    logic              w_oob, w_clamp, w_accept;
    logic [8:0]        w_col0;
    logic [PIX_W-1:0]  w_result;
    logic [17:0]       r_addr;
    logic [PIX_W-1:0]  r_pix;
    logic [8:0]        r_x, r_y;
    logic              r_oob;
    logic              w_unused;

    assign w_xi     = xp_in[22:14];
    assign w_w      = xp_in[13:14-FRAC_W];
    assign w_oob    = xp_in[23] | (w_xi > img_dim);
    assign w_clamp  = (w_xi == img_dim);
    assign w_accept = in_valid & (r_state == S_IDLE) & ~sclr;
    assign w_unused = ^{xp_in[13-FRAC_W:0], w_w};

`ifdef INTERP_BILINEAR_EN
    localparam int             SUM_W    = PIX_W + FRAC_W + 2;
    localparam logic [FRAC_W:0] ONE     = {1'b1, {FRAC_W{1'b0}}};
    localparam logic [SUM_W-1:0] HALF   = {{(SUM_W-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
    localparam state_t         RD0_NEXT = S_RD1;

    logic [17:0]       r_addr1;
    logic [FRAC_W-1:0] r_w;
    logic [PIX_W-1:0]  r_p0;
    logic [FRAC_W:0]   w_wInv;
    logic [SUM_W-1:0]  w_sum;

    assign w_col0   = w_xi;
    assign w_wInv   = ONE - {1'b0, r_w};
    assign w_sum    = SUM_W'(r_p0) * SUM_W'(w_wInv) + SUM_W'(mem_rdata) * SUM_W'(r_w) + HALF;
    assign w_result = PIX_W'(w_sum >> FRAC_W);

    // Second tap address is decided at accept; at the right edge both taps hit the same column.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr1 <= '0;
            r_w     <= '0;
            r_p0    <= '0;
        end else if (sclr) begin
            r_addr1 <= '0;
            r_w     <= '0;
            r_p0    <= '0;
        end else begin
            if (w_accept) begin
                r_addr1 <= {y_in, w_clamp ? w_xi : w_xi + 9'd1};
                r_w     <= w_w;
            end
            if (r_state == S_RD1) r_p0 <= mem_rdata;
        end
    end
`else
    localparam state_t RD0_NEXT = S_MUL;

    assign w_col0   = (w_w[FRAC_W-1] && !w_clamp) ? w_xi + 9'd1 : w_xi;
    assign w_result = mem_rdata;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        mem_rd    = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (w_accept) w_next = w_oob ? S_OUT : S_RD0;
            end
            S_RD0: begin
                mem_rd = 1'b1;
                w_next = RD0_NEXT;
            end
            S_RD1: begin
                mem_rd = 1'b1;
                w_next = S_MUL;
            end
            S_MUL: w_next = S_OUT;
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (sclr) w_next = S_IDLE;
    end

    // mem_addr is a register so it holds between reads; out-of-range pixels never touch it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
            r_pix  <= '0;
            r_x    <= '0;
            r_y    <= '0;
            r_oob  <= 1'b0;
        end else if (sclr) begin
            r_addr <= '0;
            r_pix  <= '0;
            r_x    <= '0;
            r_y    <= '0;
            r_oob  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_x   <= x_in;
                r_y   <= y_in;
                r_oob <= w_oob;
                if (w_oob) r_pix  <= FILL;
                else       r_addr <= {y_in, w_col0};
            end
`ifdef INTERP_BILINEAR_EN
            if (r_state == S_RD0) r_addr <= r_addr1;
`endif
            if (r_state == S_MUL) r_pix <= w_result;
        end
    end

    assign mem_addr = r_addr;
    assign pix_out  = r_pix;
    assign out_x    = r_x;
    assign out_y    = r_y;
    assign out_oob  = r_oob;
endmodule

// File: tb/tb_deskew_interp.sv
// tb_deskew_interp: scoreboard bench for deskew_interp; expectations follow the INTERP_BILINEAR_EN build setting.
module tb_deskew_interp;
    typedef struct {
        logic [7:0] pix;
        logic [8:0] x;
        logic [8:0] y;
        logic       oob;
        int         due;
    } exp_t;

`ifdef INTERP_BILINEAR_EN
    localparam int         LAT   = 4;
    localparam logic [7:0] EXP_Q = 8'd125;
    localparam logic [7:0] EXP_H = 8'd150;
`else
    localparam int         LAT   = 3;
    localparam logic [7:0] EXP_Q = 8'd100;
    localparam logic [7:0] EXP_H = 8'd200;
`endif

    logic        clk = 0, rst = 1, sclr = 0;
    logic [8:0]  img_dim = 9'd255;
    logic        in_valid = 0;
    logic        in_ready;
    logic [23:0] xp_in = '0;
    logic [8:0]  x_in = '0, y_in = '0;
    logic        mem_rd;
    logic [17:0] mem_addr;
    logic [7:0]  mem_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1;
    logic [7:0]  pix_out;
    logic [8:0]  out_x, out_y;
    logic        out_oob;

    int          checks = 0, errors = 0, cycle = 0;
    exp_t        outQ[$];
    logic [17:0] addrQ[$];
    exp_t        cur;
    bit          presented = 0;

    deskew_interp dut (
        .clk(clk), .rst(rst), .sclr(sclr), .img_dim(img_dim),
        .in_valid(in_valid), .in_ready(in_ready), .xp_in(xp_in), .x_in(x_in), .y_in(y_in),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .pix_out(pix_out),
        .out_x(out_x), .out_y(out_y), .out_oob(out_oob)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [7:0] memData(input logic [17:0] a);
        case (a)
            {9'd3, 9'd10}:  return 8'd100;
            {9'd3, 9'd11}:  return 8'd200;
            {9'd5, 9'd255}: return 8'd50;
            default:        return 8'hEE;
        endcase
    endfunction

    always @(posedge clk) if (mem_rd) mem_rdata <= memData(mem_addr);

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic pushAddr(input logic [8:0] row, input logic [8:0] col);
        addrQ.push_back({row, col});
    endtask

    task automatic applyStimulus(input logic [23:0] xp, input logic [8:0] x, input logic [8:0] y,
                                 input logic [7:0] pix, input logic oob, input int lat, input bit keep);
        exp_t e;
        bit   got = 0;
        xp_in = xp; x_in = x; y_in = y; in_valid = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1;
                break;
            end
        end
        if (got && keep) begin
            e.pix = pix; e.x = x; e.y = y; e.oob = oob; e.due = cycle + lat;
            outQ.push_back(e);
        end
        if (!got) checkOutput("accept_timeout", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 60 && outQ.size() != 0; i++) @(posedge clk);
        checkOutput("drain_timeout", outQ.size(), 0);
        @(posedge clk); #1;
    endtask

    // Monitor: every read address and every presented output is checked against the queues.
    always @(negedge clk) begin
        if (rst) presented = 0;
        else begin
            if (mem_rd) begin
                if (addrQ.size() == 0) checkOutput("mem_rd_unexpected", mem_rd, 0);
                else                   checkOutput("mem_addr", mem_addr, addrQ.pop_front());
            end
            if (!out_valid) presented = 0;
            else if (outQ.size() == 0) checkOutput("out_valid_unexpected", out_valid, 0);
            else begin
                if (!presented) begin
                    cur = outQ[0];
                    checkOutput("latency", cycle, cur.due);
                    presented = 1;
                end
                checkOutput("pix_out", pix_out, cur.pix);
                checkOutput("out_x", out_x, cur.x);
                checkOutput("out_y", out_y, cur.y);
                checkOutput("out_oob", out_oob, cur.oob);
                checkOutput("in_ready_busy", in_ready, 0);
                if (out_ready) begin
                    void'(outQ.pop_front());
                    presented = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_mem_rd", mem_rd, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_pix_out", pix_out, 0);
        checkOutput("rst_out_oob", out_oob, 0);
        rst = 0;
        @(posedge clk); #1;

        // Quarter-weight blend, then the two out-of-range cases and the right-edge clamp.
        pushAddr(3, 10);
`ifdef INTERP_BILINEAR_EN
        pushAddr(3, 11);
`endif
        applyStimulus(24'h029000, 9'd7, 9'd3, EXP_Q, 0, LAT, 1);
        applyStimulus(24'h800000, 9'd8, 9'd3, 8'h00, 1, 1, 1);
        pushAddr(5, 255);
`ifdef INTERP_BILINEAR_EN
        pushAddr(5, 255);
`endif
        applyStimulus(24'h3FE000, 9'd9, 9'd5, 8'd50, 0, LAT, 1);
        applyStimulus(24'h400000, 9'd10, 9'd5, 8'h00, 1, 1, 1);

        // Half weight: nearest rounds up to column 11, bilinear averages the two taps.
`ifdef INTERP_BILINEAR_EN
        pushAddr(3, 10);
`endif
        pushAddr(3, 11);
        applyStimulus(24'h02A000, 9'd11, 9'd3, EXP_H, 0, LAT, 1);

        waitDrain();
        img_dim = 9'd100;
        applyStimulus(24'h194000, 9'd12, 9'd4, 8'h00, 1, 1, 1);
        waitDrain();
        img_dim = 9'd255;

        // Back-pressure: output must hold while out_ready is low.
        out_ready = 0;
        pushAddr(3, 10);
`ifdef INTERP_BILINEAR_EN
        pushAddr(3, 11);
`endif
        applyStimulus(24'h029000, 9'd13, 9'd3, EXP_Q, 0, LAT, 1);
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        checkOutput("stall_wait_valid", out_valid, 1);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("stall_valid_held", out_valid, 1);
        out_ready = 1;
        @(posedge clk); #1;
        checkOutput("post_hs_in_ready", in_ready, 1);
        checkOutput("post_hs_out_valid", out_valid, 0);

        // Synchronous abort two cycles after accept.
        waitDrain();
        pushAddr(3, 10);
`ifdef INTERP_BILINEAR_EN
        pushAddr(3, 11);
`endif
        applyStimulus(24'h029000, 9'd14, 9'd3, EXP_Q, 0, LAT, 0);
        @(posedge clk); #1;
        sclr = 1;
        @(posedge clk); #1;
        sclr = 0;
        checkOutput("sclr_out_valid", out_valid, 0);
        checkOutput("sclr_in_ready", in_ready, 1);
        checkOutput("sclr_mem_rd", mem_rd, 0);
        checkOutput("sclr_mem_addr", mem_addr, 0);
        repeat (6) @(posedge clk);
        #1;

        // Asynchronous reset in the MUL cycle, checked before the next clock edge.
        pushAddr(3, 10);
`ifdef INTERP_BILINEAR_EN
        pushAddr(3, 11);
`endif
        applyStimulus(24'h029000, 9'd15, 9'd3, EXP_Q, 0, LAT, 0);
        repeat (LAT - 2) @(posedge clk);
        #2;
        rst = 1;
        #1;
        checkOutput("arst_out_valid", out_valid, 0);
        checkOutput("arst_in_ready", in_ready, 1);
        checkOutput("arst_mem_rd", mem_rd, 0);
        checkOutput("arst_mem_addr", mem_addr, 0);
        checkOutput("arst_pix_out", pix_out, 0);
        #1;
        rst = 0;
        @(posedge clk); #1;

        pushAddr(3, 10);
`ifdef INTERP_BILINEAR_EN
        pushAddr(3, 11);
`endif
        applyStimulus(24'h029000, 9'd16, 9'd3, EXP_Q, 0, LAT, 1);
        waitDrain();
        checkOutput("addr_left", addrQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
